turn_controller: RTL and testbench

- Consumes the player button interface: the `ready`, `command` and `dealButtonPushed` signals.
- Drives the `turnIndicator` signal back to the button interface, closing the loop.
- Sequences each round: deal request, then player turn (press/release-qualified HIT/STAND), then dealer turn.
- Hands each accepted command to the game datapath over a valid/ack handshake. Sits between the button input block and the card/score logic.

---
 rtl/turn_controller_pkg.sv | 14 +
 rtl/turn_controller_input_debouncer.sv | 50 +++++
 rtl/turn_controller.sv | 165 ++++++++++++++++
 tb/tb_turn_controller.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/turn_controller_pkg.sv
// Shared game-command encoding and the default per-round hit limit, imported by the turn
// controller and its helpers.
package turn_controller_pkg;

    typedef enum logic [1:0] {
        COMMAND_NONE  = 2'd0,
        COMMAND_HIT   = 2'd1,
        COMMAND_STAND = 2'd2
    } gameCommand;

    // The five-card limit leaves room for three hits after the initial two cards.
    localparam int unsigned DEFAULT_MAX_HITS = 3;

endpackage

// File: rtl/turn_controller_input_debouncer.sv
// Register stage for one sampled input group. With TURN_CTRL_DEBOUNCE_EN defined, the output
// follows the input only after the input has been stable for CYCLES consecutive cycles.
module turn_controller_input_debouncer #(
    parameter int unsigned      WIDTH     = 1,
    parameter int unsigned      CYCLES    = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

`ifdef TURN_CTRL_DEBOUNCE_EN
    localparam int unsigned     CNT_W   = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CYCLES - 1);

    logic [WIDTH-1:0] r_last;
    logic [CNT_W-1:0] r_cnt;

    // The counter saturates; while it sits at CNT_MAX the output tracks the stable value.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_last <= RESET_VAL;
            r_cnt  <= '0;
            r_q    <= RESET_VAL;
        end else if (i_d != r_last) begin
            r_last <= i_d;
            r_cnt  <= '0;
        end else if (r_cnt == CNT_MAX) begin
            r_q <= r_last;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end
`else
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_q <= RESET_VAL;
        end else begin
            r_q <= i_d;
        end
    end
`endif

    assign o_q = r_q;

endmodule

// File: rtl/turn_controller.sv
// Round sequencer: deal request, player HIT/STAND entry with press/release qualification,
// command handoff to the datapath, then dealer phase. Input debounce: TURN_CTRL_DEBOUNCE_EN.
module turn_controller
    import turn_controller_pkg::*;
#(
    parameter int unsigned MAX_HITS        = DEFAULT_MAX_HITS,
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    localparam int unsigned HIT_W          = $clog2(MAX_HITS + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_ready,
    input  gameCommand       i_command,
    input  logic             i_dealButtonPushed,
    input  logic             i_handOver,
    input  logic             i_dealerDone,
    input  logic             i_cmdAck,
    output logic             o_turnIndicator,
    output logic             o_cmdValid,
    output gameCommand       o_cmd,
    output logic             o_dealRequest,
    output logic             o_dealerTurn,
    output logic [HIT_W-1:0] o_hitCount
);

    typedef enum logic [2:0] {
        StIdle,
        StPlayerWait,
        StPlayerRelease,
        StIssue,
        StDealer
    } turn_state_e;

    turn_state_e      r_state, w_state_next;
    gameCommand       r_cmd_lat, w_cmd_lat_next;
    logic [HIT_W-1:0] r_hit_cnt, w_hit_cnt_next;
    logic [HIT_W-1:0] w_hit_inc;

    logic       w_ready;
    logic       w_deal;
    logic [1:0] w_cmd_bits;
    gameCommand w_cmd;
    logic       r_deal_prev;
    logic       r_smp_valid;
    logic       w_deal_rise;

    turn_controller_input_debouncer #(
        .WIDTH     (1),
        .CYCLES    (DEBOUNCE_CYCLES),
        .RESET_VAL (1'b0)
    ) u_db_ready (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_d     (i_ready),
        .o_q     (w_ready)
    );

    turn_controller_input_debouncer #(
        .WIDTH     (2),
        .CYCLES    (DEBOUNCE_CYCLES),
        .RESET_VAL (COMMAND_NONE)
    ) u_db_command (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_d     (i_command),
        .o_q     (w_cmd_bits)
    );

    turn_controller_input_debouncer #(
        .WIDTH     (1),
        .CYCLES    (DEBOUNCE_CYCLES),
        .RESET_VAL (1'b0)
    ) u_db_deal (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_d     (i_dealButtonPushed),
        .o_q     (w_deal)
    );

    assign w_cmd = gameCommand'(w_cmd_bits);

    // The sampled deal level is meaningless until one clock after reset, so the previous value
    // is held high until then; a button already down on leaving reset never forms an edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_smp_valid <= 1'b0;
            r_deal_prev <= 1'b1;
        end else begin
            r_smp_valid <= 1'b1;
            r_deal_prev <= r_smp_valid ? w_deal : 1'b1;
        end
    end

    assign w_deal_rise = w_deal & ~r_deal_prev;
    assign w_hit_inc   = r_hit_cnt + HIT_W'(1);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= StIdle;
            r_cmd_lat <= COMMAND_NONE;
            r_hit_cnt <= '0;
        end else begin
            r_state   <= w_state_next;
            r_cmd_lat <= w_cmd_lat_next;
            r_hit_cnt <= w_hit_cnt_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_cmd_lat_next = r_cmd_lat;
        w_hit_cnt_next = r_hit_cnt;
        o_dealRequest  = 1'b0;
        case (r_state)
            StIdle: begin
                if (w_deal_rise) begin
                    o_dealRequest  = 1'b1;
                    w_hit_cnt_next = '0;
                    w_state_next   = StPlayerWait;
                end
            end
            StPlayerWait: begin
                if (i_handOver) begin
                    w_state_next = StDealer;
                end else if (w_ready && (w_cmd != COMMAND_NONE)) begin
                    w_cmd_lat_next = w_cmd;
                    w_state_next   = StPlayerRelease;
                end
            end
            StPlayerRelease: begin
                if (i_handOver) begin
                    w_cmd_lat_next = COMMAND_NONE;
                    w_state_next   = StDealer;
                end else if (w_cmd == COMMAND_NONE) begin
                    w_state_next = StIssue;
                end
            end
            StIssue: begin
                if (i_cmdAck) begin
                    w_cmd_lat_next = COMMAND_NONE;
                    if (r_cmd_lat == COMMAND_HIT) begin
                        w_hit_cnt_next = w_hit_inc;
                        w_state_next   = (w_hit_inc == HIT_W'(MAX_HITS)) ? StDealer
                                                                          : StPlayerWait;
                    end else begin
                        w_state_next = StDealer;
                    end
                end
            end
            StDealer: begin
                if (i_dealerDone) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    assign o_turnIndicator = (r_state == StPlayerWait) || (r_state == StPlayerRelease);
    assign o_cmdValid      = (r_state == StIssue);
    assign o_cmd           = (r_state == StIssue) ? r_cmd_lat : COMMAND_NONE;
    assign o_dealerTurn    = (r_state == StDealer);
    assign o_hitCount      = r_hit_cnt;

endmodule

// File: tb/tb_turn_controller.sv
// Directed self-checking bench for turn_controller; the TURN_CTRL_DEBOUNCE_EN build runs a
// separate debounce sequence with DEBOUNCE_CYCLES=8.
module tb_turn_controller;
    import turn_controller_pkg::*;

    localparam int unsigned MAX_HITS = 3;
    localparam int unsigned HIT_W    = $clog2(MAX_HITS + 1);

    logic             clk;
    logic             rst_n;
    logic             ready;
    gameCommand       command;
    logic             deal;
    logic             hand_over;
    logic             dealer_done;
    logic             cmd_ack;
    logic             turn_ind;
    logic             cmd_valid;
    gameCommand       cmd;
    logic             deal_req;
    logic             dealer_turn;
    logic [HIT_W-1:0] hit_count;

    int n_checks = 0;
    int n_errors = 0;

    turn_controller #(
        .MAX_HITS        (MAX_HITS),
        .DEBOUNCE_CYCLES (8)
    ) dut (
        .i_clk              (clk),
        .i_rst_n            (rst_n),
        .i_ready            (ready),
        .i_command          (command),
        .i_dealButtonPushed (deal),
        .i_handOver         (hand_over),
        .i_dealerDone       (dealer_done),
        .i_cmdAck           (cmd_ack),
        .o_turnIndicator    (turn_ind),
        .o_cmdValid         (cmd_valid),
        .o_cmd              (cmd),
        .o_dealRequest      (deal_req),
        .o_dealerTurn       (dealer_turn),
        .o_hitCount         (hit_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_turn"}, {31'd0, turn_ind}, 0);
        chk({tag, "_valid"}, {31'd0, cmd_valid}, 0);
        chk({tag, "_cmd"}, {30'd0, cmd}, COMMAND_NONE);
        chk({tag, "_dreq"}, {31'd0, deal_req}, 0);
        chk({tag, "_dturn"}, {31'd0, dealer_turn}, 0);
        chk({tag, "_hits"}, 32'(hit_count), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; ready = 1'b0; command = COMMAND_NONE; deal = 1'b0;
        hand_over = 1'b0; dealer_done = 1'b0; cmd_ack = 1'b0;
        #2;
        chk_all_zero("reset");
        cyc(); cyc();
        rst_n = 1'b1;
`ifndef TURN_CTRL_DEBOUNCE_EN
        cyc();
        chk("idle_turn", {31'd0, turn_ind}, 0);
        // Deal pressed one cycle
        deal = 1'b1; cyc();
        chk("deal_req_hi", {31'd0, deal_req}, 1);
        chk("deal_req_turn0", {31'd0, turn_ind}, 0);
        deal = 1'b0; cyc();
        chk("deal_req_lo", {31'd0, deal_req}, 0);
        chk("deal_turn1", {31'd0, turn_ind}, 1);
        chk("deal_hits0", 32'(hit_count), 0);
        // HIT held 5 cycles, ack on the third valid cycle
        command = COMMAND_HIT; ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("hit1_held_novalid", {31'd0, cmd_valid}, 0);
        end
        command = COMMAND_NONE; ready = 1'b0; cyc();
        chk("hit1_release_novalid", {31'd0, cmd_valid}, 0);
        for (int i = 0; i < 3; i++) begin
            if (i == 0) cyc(); else cyc();
            chk("hit1_valid", {31'd0, cmd_valid}, 1);
            chk("hit1_cmd", {30'd0, cmd}, COMMAND_HIT);
            chk("hit1_turn0", {31'd0, turn_ind}, 0);
            if (i == 2) cmd_ack = 1'b1;
        end
        cyc(); cmd_ack = 1'b0;
        chk("hit1_done_valid", {31'd0, cmd_valid}, 0);
        chk("hit1_hits", 32'(hit_count), 1);
        chk("hit1_back_turn", {31'd0, turn_ind}, 1);
        // Second HIT: switch to STAND while held, ack on the cycle valid rises
        command = COMMAND_HIT; ready = 1'b1; cyc(); cyc();
        command = COMMAND_STAND; cyc();
        command = COMMAND_NONE; ready = 1'b0; cyc();
        chk("hit2_held_novalid", {31'd0, cmd_valid}, 0);
        cyc();
        chk("hit2_valid", {31'd0, cmd_valid}, 1);
        chk("hit2_first_wins", {30'd0, cmd}, COMMAND_HIT);
        cmd_ack = 1'b1; cyc(); cmd_ack = 1'b0;
        chk("hit2_hits", 32'(hit_count), 2);
        chk("hit2_turn", {31'd0, turn_ind}, 1);
        // Third HIT reaches the limit and ends the turn
        command = COMMAND_HIT; ready = 1'b1; cyc(); cyc();
        command = COMMAND_NONE; ready = 1'b0; cyc(); cyc();
        chk("hit3_valid", {31'd0, cmd_valid}, 1);
        cmd_ack = 1'b1; cyc(); cmd_ack = 1'b0;
        chk("hit3_hits", 32'(hit_count), 3);
        chk("hit3_dealer", {31'd0, dealer_turn}, 1);
        chk("hit3_turn0", {31'd0, turn_ind}, 0);
        // Deal press during dealer phase is ignored
        deal = 1'b1; cyc();
        chk("dealer_deal_ign", {31'd0, deal_req}, 0);
        deal = 1'b0; cyc();
        chk("dealer_still", {31'd0, dealer_turn}, 1);
        dealer_done = 1'b1; cyc(); dealer_done = 1'b0;
        chk("done_idle_dturn", {31'd0, dealer_turn}, 0);
        chk("done_hits_hold", 32'(hit_count), 3);
        cyc();
        chk("done_no_turn", {31'd0, turn_ind}, 0);
        // New round: STAND with simultaneous handOver
        deal = 1'b1; cyc();
        chk("r2_deal_req", {31'd0, deal_req}, 1);
        deal = 1'b0; cyc();
        chk("r2_hits_clr", 32'(hit_count), 0);
        command = COMMAND_STAND; ready = 1'b1; hand_over = 1'b1; cyc();
        chk("r2_ho_dealer", {31'd0, dealer_turn}, 1);
        chk("r2_ho_novalid", {31'd0, cmd_valid}, 0);
        hand_over = 1'b0; command = COMMAND_NONE; ready = 1'b0;
        cyc(); cyc();
        chk("r2_ho_novalid2", {31'd0, cmd_valid}, 0);
        dealer_done = 1'b1; cyc(); dealer_done = 1'b0;
        // handOver while waiting for release discards the command
        deal = 1'b1; cyc(); deal = 1'b0; cyc();
        command = COMMAND_HIT; ready = 1'b1; cyc(); cyc();
        hand_over = 1'b1; cyc(); hand_over = 1'b0;
        command = COMMAND_NONE; ready = 1'b0;
        chk("r3_rel_ho_dealer", {31'd0, dealer_turn}, 1);
        cyc();
        chk("r3_rel_ho_novalid", {31'd0, cmd_valid}, 0);
        chk("r3_rel_ho_hits", 32'(hit_count), 0);
        dealer_done = 1'b1; cyc(); dealer_done = 1'b0;
        // STAND latched, reset asserted while in ISSUE
        deal = 1'b1; cyc(); deal = 1'b0; cyc();
        command = COMMAND_STAND; ready = 1'b1; cyc(); cyc();
        command = COMMAND_NONE; ready = 1'b0; cyc(); cyc();
        chk("r4_stand_valid", {31'd0, cmd_valid}, 1);
        chk("r4_stand_cmd", {30'd0, cmd}, COMMAND_STAND);
        #2 rst_n = 1'b0;
        #1;
        chk_all_zero("async_rst");
        // Deal held through reset release forms no edge
        deal = 1'b1;
        cyc(); rst_n = 1'b1;
        cyc();
        chk("held_deal_noreq1", {31'd0, deal_req}, 0);
        cyc();
        chk("held_deal_noreq2", {31'd0, deal_req}, 0);
        chk("held_deal_idle", {31'd0, turn_ind}, 0);
        deal = 1'b0; cyc(); cyc();
        chk("post_rst_idle", {31'd0, turn_ind}, 0);
        deal = 1'b1; cyc();
        chk("post_rst_deal_req", {31'd0, deal_req}, 1);
        deal = 1'b0; cyc();
        chk("post_rst_turn", {31'd0, turn_ind}, 1);
`else
        begin
            logic seen;
            logic seen_valid;
            int   n_valid;
            deal = 1'b1; seen = 1'b0;
            for (int i = 0; i < 30; i++) begin
                cyc();
                if (deal_req) begin
                    seen = 1'b1;
                    break;
                end
            end
            chk("db_deal_req", {31'd0, seen}, 1);
            deal = 1'b0; seen = 1'b0;
            for (int i = 0; i < 30; i++) begin
                cyc();
                if (turn_ind) begin
                    seen = 1'b1;
                    break;
                end
            end
            chk("db_turn", {31'd0, seen}, 1);
            ready = 1'b1; seen_valid = 1'b0;
            for (int k = 0; k < 40; k++) begin
                command = ((k / 4) % 2 == 1) ? COMMAND_NONE : COMMAND_HIT;
                cyc();
                if (cmd_valid) seen_valid = 1'b1;
            end
            command = COMMAND_NONE;
            for (int k = 0; k < 20; k++) begin
                cyc();
                if (cmd_valid) seen_valid = 1'b1;
            end
            chk("db_glitch_novalid", {31'd0, seen_valid}, 0);
            chk("db_glitch_turn", {31'd0, turn_ind}, 1);
            command = COMMAND_HIT;
            for (int k = 0; k < 12; k++) cyc();
            command = COMMAND_NONE; seen_valid = 1'b0;
            for (int k = 0; k < 30; k++) begin
                cyc();
                if (cmd_valid) begin
                    seen_valid = 1'b1;
                    break;
                end
            end
            chk("db_valid", {31'd0, seen_valid}, 1);
            chk("db_cmd", {30'd0, cmd}, COMMAND_HIT);
            cmd_ack = 1'b1; cyc(); cmd_ack = 1'b0;
            chk("db_hits", 32'(hit_count), 1);
            n_valid = 0;
            for (int k = 0; k < 30; k++) begin
                cyc();
                if (cmd_valid) n_valid++;
            end
            chk("db_single_issue", 32'(n_valid), 0);
        end
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
